// File: rtl/ifq_pkg.sv
// ifq_pkg: definitions shared by the instruction fetch controller and the IFQ.
//   ifq_state_e          fetch controller FSM state encoding
//   LINE_BYTES           bytes per cache line (fetch address stride)
//   DEF_CACHE_LINE_WIDTH default line width in bits
//   DEF_ADDR_WIDTH       default byte-address width
package ifq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // one cycle after reset before the first request
    S_REQ  = 2'd1,  // cache read outstanding, waiting for the line
    S_PUSH = 2'd2,  // line buffered, presenting it to the IFQ
    S_DROP = 2'd3   // a stale line is still in flight and must be discarded
  } ifq_state_e;

  localparam int LINE_BYTES           = 16;
  localparam int DEF_CACHE_LINE_WIDTH = 128;
  localparam int DEF_ADDR_WIDTH       = 32;

endpackage

// File: rtl/ifq_fetch_ctrl.sv
// ifq_fetch_ctrl: sequential instruction-line fetcher feeding the IFQ.
// Requests one cache line at a time, buffers the returned line and pushes it
// into the IFQ. A jump/branch redirect restarts fetching at the target line;
// the first line after a redirect is delivered with flush instead of a write.
//
// Ports
//   clk                 clock, all logic on the rising edge
//   rst                 synchronous active-low reset
//   Jmp_Branch_valid    redirect request (one-cycle pulse)
//   Jmp_Branch_address  redirect byte address
//   Cache_dout_valid    cache line returned this cycle
//   Cache_dout          returned cache line
//   fifo_full           IFQ cannot accept a write
//   Rd_en               cache read request
//   PC_out              line-aligned request address
//   fifo_write_en       push Data_in into the IFQ
//   flush               flush the IFQ and load Data_in as its entry 0
//   Jmp_Branch_Bits_2_3 word offset of the redirect target in the flushed line
//   Data_in             line presented to the IFQ
module ifq_fetch_ctrl
  import ifq_pkg::*;
#(
  parameter int                    CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH,
  parameter int                    ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Jmp_Branch_valid,
  input  logic [ADDR_WIDTH-1:0]       Jmp_Branch_address,
  input  logic                        Cache_dout_valid,
  input  logic [CACHE_LINE_WIDTH-1:0] Cache_dout,
  input  logic                        fifo_full,
  output logic                        Rd_en,
  output logic [ADDR_WIDTH-1:0]       PC_out,
  output logic                        fifo_write_en,
  output logic                        flush,
  output logic [1:0]                  Jmp_Branch_Bits_2_3,
  output logic [CACHE_LINE_WIDTH-1:0] Data_in
);

  ifq_state_e                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]       pc_reg, pc_next;
  logic [CACHE_LINE_WIDTH-1:0] line_reg, line_next;
  logic [1:0]                  bits_reg, bits_next;
  logic                        flush_pending_reg, flush_pending_next;

  logic                        redirect;
  logic                        flush_int;
  logic                        write_int;
  logic [ADDR_WIDTH-1:0]       redirect_pc;

  // Only the line-aligned part and the word offset of the target are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Jmp_Branch_address[1:0];

  assign redirect    = Jmp_Branch_valid && (state_reg != S_IDLE);
  assign redirect_pc = {Jmp_Branch_address[ADDR_WIDTH-1:4], 4'b0000};

  // A pending flush is delivered whether or not the IFQ is full, since the
  // flush empties it anyway; plain writes wait for space.
  assign flush_int = (state_reg == S_PUSH) && flush_pending_reg;
  assign write_int = (state_reg == S_PUSH) && !flush_pending_reg && !fifo_full;

  // Strobes are gated by rst so they are already low during the cycle in
  // which reset is being applied, not only after the reset edge.
  assign Rd_en               = rst && (state_reg == S_REQ);
  assign fifo_write_en       = rst && write_int;
  assign flush               = rst && flush_int;
  assign PC_out              = pc_reg;
  assign Jmp_Branch_Bits_2_3 = bits_reg;
  assign Data_in             = line_reg;

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    line_next          = line_reg;
    bits_next          = bits_reg;
    flush_pending_next = flush_pending_reg;

    case (state_reg)
      S_IDLE: begin
        state_next = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          // A line arriving together with the redirect is stale; if none
          // arrived yet, it is still in flight and must be dropped later.
          state_next = Cache_dout_valid ? S_REQ : S_DROP;
        end else if (Cache_dout_valid) begin
          line_next  = Cache_dout;
          state_next = S_PUSH;
        end
      end
      S_PUSH: begin
        if (redirect) begin
          // Any push driven this cycle stands; the buffer is abandoned.
          state_next = S_REQ;
        end else if (flush_int || write_int) begin
          pc_next            = pc_reg + ADDR_WIDTH'(LINE_BYTES);
          flush_pending_next = 1'b0;
          state_next         = S_REQ;
        end
      end
      S_DROP: begin
        // Once the stale line is consumed nothing is outstanding, so a
        // redirect in the same cycle simply retargets the new request.
        if (Cache_dout_valid) begin
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Redirect overrides any sequential PC advance; last redirect wins.
    if (redirect) begin
      pc_next            = redirect_pc;
      bits_next          = Jmp_Branch_address[3:2];
      flush_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= S_IDLE;
      pc_reg            <= RESET_PC;
      line_reg          <= '0;
      bits_reg          <= 2'b00;
      flush_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      line_reg          <= line_next;
      bits_reg          <= bits_next;
      flush_pending_reg <= flush_pending_next;
    end
  end

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// tb_ifq_fetch_ctrl: directed scoreboard bench for ifq_fetch_ctrl.
// A behavioural cache (latency 2) answers read requests; expected requests and
// IFQ pushes are queued up front and popped by monitors at the falling edge.
module tb_ifq_fetch_ctrl;

  localparam int CLW = 128;
  localparam int AW  = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           Jmp_Branch_valid;
  logic [AW-1:0]  Jmp_Branch_address;
  logic           Cache_dout_valid;
  logic [CLW-1:0] Cache_dout;
  logic           fifo_full;
  logic           Rd_en;
  logic [AW-1:0]  PC_out;
  logic           fifo_write_en;
  logic           flush;
  logic [1:0]     Jmp_Branch_Bits_2_3;
  logic [CLW-1:0] Data_in;

  always #5 clk = ~clk;

  ifq_fetch_ctrl #(
    .CACHE_LINE_WIDTH(CLW),
    .ADDR_WIDTH      (AW),
    .RESET_PC        (32'h0)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .Jmp_Branch_valid   (Jmp_Branch_valid),
    .Jmp_Branch_address (Jmp_Branch_address),
    .Cache_dout_valid   (Cache_dout_valid),
    .Cache_dout         (Cache_dout),
    .fifo_full          (fifo_full),
    .Rd_en              (Rd_en),
    .PC_out             (PC_out),
    .fifo_write_en      (fifo_write_en),
    .flush              (flush),
    .Jmp_Branch_Bits_2_3(Jmp_Branch_Bits_2_3),
    .Data_in            (Data_in)
  );

  typedef struct {
    logic           is_flush;
    logic [1:0]     bits;
    logic [CLW-1:0] data;
  } push_t;

  int            total = 0;
  int            bad   = 0;
  logic [AW-1:0] exp_req_q[$];
  push_t         exp_push_q[$];

  // Cache contents: each line is a distinct pattern derived from its address.
  function automatic logic [CLW-1:0] line_of(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | {16'h0, a[15:0]}};
  endfunction

  task automatic check(input string name, input logic [CLW-1:0] act, input logic [CLW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic exp_push(input logic f, input logic [1:0] b, input logic [AW-1:0] a);
    push_t p;
    p.is_flush = f;
    p.bits     = b;
    p.data     = line_of(a);
    exp_push_q.push_back(p);
  endtask

  // Wait (bounded) until the DUT requests the given line address.
  task automatic wait_req(input logic [AW-1:0] a);
    int n;
    n = 0;
    while (!(Rd_en === 1'b1 && PC_out === a) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL wait_req: no request seen, PC_out %0h want %0h", PC_out, a);
    end
  endtask

  // Wait (bounded) until a returned line has just been captured.
  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (Cache_dout_valid !== 1'b1 && n < 60);
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL wait_valid: cache never returned a line, got %0d want 1", Cache_dout_valid);
    end
  endtask

  task automatic pulse_jmp(input logic [AW-1:0] a);
    Jmp_Branch_valid   = 1'b1;
    Jmp_Branch_address = a;
    @(posedge clk); #1;
    Jmp_Branch_valid   = 1'b0;
  endtask

  // Cache model and request monitor.
  initial begin : cache_model
    logic [AW-1:0] req_addr;
    logic          outstanding;
    int            cnt;
    Cache_dout_valid = 1'b0;
    Cache_dout       = '0;
    outstanding      = 1'b0;
    cnt              = 0;
    req_addr         = '0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        Cache_dout_valid = 1'b0;
        Cache_dout       = '0;
        outstanding      = 1'b0;
        cnt              = 0;
      end else begin
        if (Cache_dout_valid) begin
          Cache_dout_valid = 1'b0;
          Cache_dout       = '0;
          outstanding      = 1'b0;
        end else if (outstanding) begin
          cnt--;
          if (cnt == 0) begin
            Cache_dout_valid = 1'b1;
            Cache_dout       = line_of(req_addr);
          end
          if (Rd_en === 1'b1 && PC_out !== req_addr) begin
            total++;
            bad++;
            $display("FAIL pc_stable: got %0h want %0h", PC_out, req_addr);
          end
        end
        if (!outstanding && Rd_en === 1'b1) begin
          outstanding = 1'b1;
          req_addr    = PC_out;
          cnt         = 2;
          total++;
          if (exp_req_q.size() == 0) begin
            bad++;
            $display("FAIL req: got unexpected request %0h want none", PC_out);
          end else begin
            logic [AW-1:0] e;
            e = exp_req_q.pop_front();
            if (PC_out !== e) begin
              bad++;
              $display("FAIL req: got %0h want %0h", PC_out, e);
            end else begin
              $display("req  %0h", PC_out);
            end
          end
        end
      end
    end
  end

  // IFQ push monitor.
  initial begin : push_monitor
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (flush === 1'b1 && fifo_write_en === 1'b1) begin
          total++;
          bad++;
          $display("FAIL exclusive: got write=1 flush=1 want at most one");
        end
        if (fifo_write_en === 1'b1 || flush === 1'b1) begin
          total++;
          if (exp_push_q.size() == 0) begin
            bad++;
            $display("FAIL push: got unexpected push flush=%0d data %0h want none", flush, Data_in);
          end else begin
            push_t p;
            p = exp_push_q.pop_front();
            if (flush !== p.is_flush || Data_in !== p.data ||
                (p.is_flush && Jmp_Branch_Bits_2_3 !== p.bits)) begin
              bad++;
              $display("FAIL push: got flush=%0d bits=%0d data %0h want flush=%0d bits=%0d data %0h",
                       flush, Jmp_Branch_Bits_2_3, Data_in, p.is_flush, p.bits, p.data);
            end else begin
              $display("push flush=%0d bits=%0d data %0h", flush, Jmp_Branch_Bits_2_3, Data_in);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst                = 1'b0;
    Jmp_Branch_valid   = 1'b0;
    Jmp_Branch_address = '0;
    fifo_full          = 1'b0;

    // Expected request sequence.
    exp_req_q = '{32'h0, 32'h10, 32'h20, 32'h30, 32'h40, 32'h1230, 32'h1240,
                  32'h2000, 32'h2010, 32'h2020, 32'h200, 32'h210, 32'h0, 32'h10};
    // Expected IFQ pushes.
    exp_push(1'b0, 2'b00, 32'h0);
    exp_push(1'b0, 2'b00, 32'h10);
    exp_push(1'b0, 2'b00, 32'h20);
    exp_push(1'b0, 2'b00, 32'h30);
    exp_push(1'b1, 2'b10, 32'h1230);
    exp_push(1'b1, 2'b01, 32'h2000);
    exp_push(1'b0, 2'b00, 32'h2010);
    exp_push(1'b1, 2'b01, 32'h200);
    exp_push(1'b0, 2'b00, 32'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", CLW'(Rd_en), CLW'(1'b0));
    check("rst_write", CLW'(fifo_write_en), CLW'(1'b0));
    check("rst_flush", CLW'(flush), CLW'(1'b0));
    check("rst_pc", CLW'(PC_out), CLW'(32'h0));
    check("rst_data", Data_in, '0);
    check("rst_bits", CLW'(Jmp_Branch_Bits_2_3), CLW'(2'b00));
    rst = 1'b1;
    check("idle_rd_en", CLW'(Rd_en), CLW'(1'b0));

    // Streaming, then IFQ full for 5 cycles while line 0x30 is held.
    wait_req(32'h30);
    fifo_full = 1'b1;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("full_hold_write", CLW'(fifo_write_en), CLW'(1'b0));
      check("full_hold_data", Data_in, line_of(32'h30));
      @(posedge clk); #1;
    end
    fifo_full = 1'b0;

    // Redirect while request 0x40 is outstanding -> stale line dropped.
    wait_req(32'h40);
    pulse_jmp(32'h1238);

    // Redirect while a line is held behind a full IFQ.
    wait_req(32'h1240);
    fifo_full = 1'b1;
    wait_valid();
    check("held_no_write", CLW'(fifo_write_en), CLW'(1'b0));
    pulse_jmp(32'h2004);
    wait_req(32'h2010);
    fifo_full = 1'b0;

    // Two redirects back to back; the second one wins.
    wait_req(32'h2020);
    pulse_jmp(32'h100);
    pulse_jmp(32'h204);

    // Reset while holding a line behind a full IFQ.
    wait_req(32'h210);
    fifo_full = 1'b1;
    wait_valid();
    rst = 1'b0;
    #1;
    check("rst_mid_write", CLW'(fifo_write_en), CLW'(1'b0));
    check("rst_mid_flush", CLW'(flush), CLW'(1'b0));
    @(posedge clk); #1;
    check("rst_mid_rd_en", CLW'(Rd_en), CLW'(1'b0));
    check("rst_mid_pc", CLW'(PC_out), CLW'(32'h0));
    check("rst_mid_data", Data_in, '0);
    check("rst_mid_bits", CLW'(Jmp_Branch_Bits_2_3), CLW'(2'b00));
    rst       = 1'b1;
    fifo_full = 1'b0;
    wait_req(32'h0);
    wait_req(32'h10);
    repeat (2) @(posedge clk);
    #1;
    check("req_left", CLW'(exp_req_q.size()), CLW'(0));
    check("push_left", CLW'(exp_push_q.size()), CLW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
